button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Front-end conditioner placed directly upstream of ButtonSync. Converts a raw, bouncing,
//  asynchronous push-button into a clean synchronous level (Bo) that drives ButtonSync's Bis.
//  Also emits one-cycle press/release pulses and a long-press indicator for the step/run controls.
// PARAMETERS
//  SYNC_STAGES   2           synchronizer flops on Bis (>=2)
//  STABLE_CYCLES 1_000_000   cycles the input must stay constant to accept a change (20 ms @ 50 MHz; >=2)
//  HOLD_CYCLES   25_000_000  cycles after an accepted press before Held asserts (0.5 s @ 50 MHz; >=1)
// PORTS
//  Clk    in   1  system clock, all state on posedge
//  Reset  in   1  asynchronous, active-high reset
//  Bis    in   1  raw button, asynchronous to Clk, may bounce
//  Bo     out  1  debounced level, registered; feeds ButtonSync.Bis
//  Rise   out  1  one-cycle pulse, same cycle Bo goes 0->1
//  Fall   out  1  one-cycle pulse, same cycle Bo goes 1->0
//  Held   out  1  level: pressed continuously for >= HOLD_CYCLES since Rise
// BEHAVIOUR
//  - Reset (async assert, release on Clk): sync flops=0, state=S_IDLE, counters=0; Bo/Rise/Fall/Held=0.
//  - Bs = output of SYNC_STAGES-deep synchronizer; FSM sees only Bs, never Bis.
//  - FSM states, stable counter Cnt (width $clog2(STABLE_CYCLES)):
//    S_IDLE:   Bo=0. Bs=1 -> S_PWAIT, Cnt<=0.
//    S_PWAIT:  Bo=0. Bs=0 -> S_IDLE (bounce rejected). Bs=1 & Cnt==STABLE_CYCLES-1 -> S_DOWN, Rise=1.
//              else Cnt<=Cnt+1.
//    S_DOWN:   Bo=1. Bs=0 -> S_RWAIT, Cnt<=0.
//    S_RWAIT:  Bo=1. Bs=1 -> S_DOWN (glitch rejected, no pulse). Bs=0 & Cnt==STABLE_CYCLES-1 -> S_IDLE,
//              Fall=1. else Cnt<=Cnt+1.
//    Unused encodings -> S_IDLE, outputs 0.
//  - Bo, Rise, Fall, Held are all registered outputs (no combinational path from Bis).
//  - Latency: counting the first edge that samples a steady Bis=1 as edge 1, Bo and Rise assert after
//    edge SYNC_STAGES+STABLE_CYCLES+1; release is symmetric for Bo/Fall.
//  - Any Bs change before Cnt reaches STABLE_CYCLES-1 restarts the qualification; Cnt never wraps.
//  - Rise and Fall never assert in the same cycle; each asserts exactly one cycle per accepted edge.
//  - Hold counter HCnt (width $clog2(HOLD_CYCLES+1)): cleared on Rise; increments in S_DOWN/S_RWAIT;
//    saturates at HOLD_CYCLES, no wrap. Held=1 when HCnt==HOLD_CYCLES, i.e. HOLD_CYCLES edges after Rise.
//    A rejected release glitch does not clear HCnt. Held clears in the cycle Fall asserts.
//  - Reset mid-operation (any state): outputs drop to 0 immediately, no Fall pulse; after release,
//    a button still held is re-qualified from S_IDLE (full latency, new Rise).
// STRUCTURE
//  - Package button_pkg: typedef enum logic [1:0] {S_IDLE,S_PWAIT,S_DOWN,S_RWAIT} debounce_state_t;
//    default timing constants (CLK_HZ=50_000_000, DEBOUNCE_MS=20, HOLD_MS=500).
//  - Sub-module sync_ff #(STAGES) (Clk, Reset, D, Q): N-flop synchronizer, reusable for switches.
//  - Top: one always_ff (state, Cnt, HCnt, registered outputs) + one always_comb next-state/output.
// TESTING (bench params: SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=16; 50 MHz clock)
//  1 Reset with Bis=1 for 10 cycles -> Bo/Rise/Fall/Held=0 throughout; after release Rise at edge 7.
//  2 Clean press: Bis 0->1, held 20 cycles -> Bo=1 and single Rise after edge 7; no Fall.
//  3 Bounce: Bis toggles every 2 cycles for 12 cycles, then 1 -> no Rise during bounce; exactly one
//    Rise after the 7th edge following the last 0->1 transition.
//  4 Release glitch: Bo=1, Bis=0 for 3 cycles then 1 -> Bo stays 1, no Fall, no Rise.
//  5 Long press: Bis=1 for 40 cycles then 0 -> Held=1 16 edges after Rise; on release, Fall pulse
//    after edge 7 of the release, Held=0 same cycle.
//  6 Reset asserted in S_RWAIT (mid-release) -> Bo/Held=0 immediately, no Fall pulse at any time.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and default timing for the push-button front end.
// Cycle counts are derived from the board clock so callers can retune in one place.
package button_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PWAIT = 2'd1,
    S_DOWN  = 2'd2,
    S_RWAIT = 2'd3
  } debounce_state_t;

  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 20;
  localparam int HOLD_MS     = 500;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int DEF_HOLD_CYCLES   = ms_to_cycles(CLK_HZ, HOLD_MS);

endpackage

// File: rtl/button_sync_ff.sv
// N-flop synchronizer for asynchronous single-bit inputs (buttons, switches).
// STAGES must be at least 2; the first flop may go metastable, later ones filter it.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], D};
    end
  end

  assign Q = sr[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw push-button into a clean level plus press/release pulses and a long-press flag.
// All outputs are registered; the FSM only ever observes the synchronized input.
module button_debounce
  import button_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Bis,
  output logic       Bo,
  output logic       Rise,
  output logic       Fall,
  output logic       Held,
  output logic [1:0] State
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic            bs;
  debounce_state_t state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [HW-1:0]   hcnt, hcnt_nxt;
  logic            bo_nxt, rise_nxt, fall_nxt, held_nxt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .D     (Bis),
    .Q     (bs)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      hcnt  <= '0;
      Bo    <= 1'b0;
      Rise  <= 1'b0;
      Fall  <= 1'b0;
      Held  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hcnt  <= hcnt_nxt;
      Bo    <= bo_nxt;
      Rise  <= rise_nxt;
      Fall  <= fall_nxt;
      Held  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hcnt_nxt  = hcnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        if (bs) begin
          state_nxt = S_PWAIT;
          cnt_nxt   = '0;
        end
      end
      S_PWAIT: begin
        if (!bs) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_DOWN;
          rise_nxt  = 1'b1;
          hcnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DOWN: begin
        if (hcnt != HOLD_MAX) hcnt_nxt = hcnt + 1'b1;
        if (!bs) begin
          state_nxt = S_RWAIT;
          cnt_nxt   = '0;
        end
      end
      S_RWAIT: begin
        // Hold time keeps accruing through a release glitch so it never restarts the long press.
        if (hcnt != HOLD_MAX) hcnt_nxt = hcnt + 1'b1;
        if (bs) begin
          state_nxt = S_DOWN;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_IDLE;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    bo_nxt   = (state_nxt == S_DOWN) || (state_nxt == S_RWAIT);
    held_nxt = bo_nxt && (hcnt_nxt == HOLD_MAX);
  end

  assign State = state;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: expected pulse events are queued with their cycle stamps
// and a negedge monitor pops and compares them whenever Rise, Fall or a Held assertion appears.
module tb_button_debounce;

  localparam logic [1:0] K_RISE = 2'd1;
  localparam logic [1:0] K_FALL = 2'd2;
  localparam logic [1:0] K_HELD = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       bis;
  logic       bo, rise, fall, held;
  logic [1:0] state;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic held_prev = 1'b0;

  logic [31:0] exp_q[$];

  button_debounce #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .HOLD_CYCLES   (16)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .Bis   (bis),
    .Bo    (bo),
    .Rise  (rise),
    .Fall  (fall),
    .Held  (held),
    .State (state)
  );

  // clock / reset block
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ev(input logic [1:0] k, input int c);
    logic [31:0] cc;
    cc = c;
    return {k, cc[29:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_evt(input logic [1:0] kind);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      check("event", ev(kind, cyc), exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive_at(input int c, input logic v);
    wait_until(c);
    bis = v;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      held_prev = 1'b0;
    end else begin
      if (rise && fall) check("rise_fall_overlap", 32'({rise, fall}), 32'd0);
      if (rise) begin
        check_evt(K_RISE);
        check("bo_on_rise", 32'(bo), 32'd1);
      end
      if (fall) begin
        check_evt(K_FALL);
        check("bo_on_fall", 32'(bo), 32'd0);
        check("held_on_fall", 32'(held), 32'd0);
      end
      if (held && !held_prev) check_evt(K_HELD);
      if (!held && held_prev && !fall) check("held_drop_without_fall", 32'(held), 32'd1);
      held_prev = held;
    end
  end

  initial begin
    int c;
    rst = 1'b1;
    bis = 1'b1;
    @(negedge clk);

    // 1: reset held with button pressed, then qualification from release
    for (int i = 0; i < 10; i++) begin
      check("reset_outputs", 32'({bo, rise, fall, held}), 32'd0);
      @(negedge clk);
    end
    c = cyc;
    exp_q.push_back(ev(K_RISE, c + 7));
    exp_q.push_back(ev(K_FALL, c + 17));
    rst = 1'b0;
    drive_at(c + 10, 1'b0);
    wait_until(c + 27);

    // 2: clean press of 20 cycles
    c = cyc;
    exp_q.push_back(ev(K_RISE, c + 7));
    exp_q.push_back(ev(K_HELD, c + 23));
    exp_q.push_back(ev(K_FALL, c + 27));
    bis = 1'b1;
    wait_until(c + 6);
    check("bo_before_rise", 32'(bo), 32'd0);
    wait_until(c + 10);
    check("bo_pressed", 32'(bo), 32'd1);
    drive_at(c + 20, 1'b0);
    wait_until(c + 37);

    // 3: bounce for 12 cycles, then settle high
    c = cyc;
    exp_q.push_back(ev(K_RISE, c + 19));
    exp_q.push_back(ev(K_FALL, c + 31));
    for (int i = 0; i < 12; i++) drive_at(c + i, ((i / 2) % 2) == 0);
    check("bo_during_bounce", 32'(bo), 32'd0);
    drive_at(c + 12, 1'b1);
    drive_at(c + 24, 1'b0);
    wait_until(c + 41);

    // 4: release glitch of 3 cycles is rejected and does not reset hold time
    c = cyc;
    exp_q.push_back(ev(K_RISE, c + 7));
    exp_q.push_back(ev(K_HELD, c + 23));
    exp_q.push_back(ev(K_FALL, c + 29));
    bis = 1'b1;
    drive_at(c + 12, 1'b0);
    drive_at(c + 15, 1'b1);
    for (int i = 8; i < 22; i += 3) begin
      wait_until(c + i);
      check("bo_through_glitch", 32'(bo), 32'd1);
    end
    drive_at(c + 22, 1'b0);
    wait_until(c + 39);

    // 5: long press of 40 cycles
    c = cyc;
    exp_q.push_back(ev(K_RISE, c + 7));
    exp_q.push_back(ev(K_HELD, c + 23));
    exp_q.push_back(ev(K_FALL, c + 47));
    bis = 1'b1;
    wait_until(c + 22);
    check("held_before_hold", 32'(held), 32'd0);
    wait_until(c + 35);
    check("held_saturated", 32'(held), 32'd1);
    drive_at(c + 40, 1'b0);
    wait_until(c + 57);

    // 6: reset during release qualification
    c = cyc;
    exp_q.push_back(ev(K_RISE, c + 7));
    exp_q.push_back(ev(K_HELD, c + 23));
    bis = 1'b1;
    drive_at(c + 30, 1'b0);
    wait_until(c + 35);
    check("state_rwait", 32'(state), 32'd3);
    check("bo_before_reset", 32'({bo, held}), 32'd3);
    rst = 1'b1;
    #1;
    check("outputs_on_reset", 32'({bo, rise, fall, held}), 32'd0);
    wait_until(c + 38);
    rst = 1'b0;
    wait_until(c + 60);
    check("bo_after_reset", 32'({bo, held}), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
